toeplitz_word_streamer: RTL and testbench

//  Downstream of toeplitz_p: captures each L-bit extracted block (q on qstrobe) into a small

---
 rtl/toeplitz_pkg.sv | 14 +
 rtl/block_fifo.sv | 44 ++++
 rtl/toeplitz_word_streamer.sv | 96 +++++++++
 tb/tb_toeplitz_word_streamer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toeplitz_pkg.sv
// Shared definitions for the toeplitz extractor family: default block geometry
// and the block/word relationship used by the extractor, serializer and word streamer.
package toeplitz_pkg;

    localparam int DEFAULT_L  = 128;
    localparam int DEFAULT_OW = 8;

    typedef logic [DEFAULT_L-1:0] block_t;

    function automatic int words_per_block(input int l, input int ow);
        return l / ow;
    endfunction

endpackage

// File: rtl/block_fifo.sv
// Small FIFO of whole blocks; the head entry is always visible on data_out.
// A push is allowed while full only when a pop frees the head slot on the same edge.
module block_fifo
    import toeplitz_pkg::*;
#(
    parameter int W     = DEFAULT_L,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    assign data_out = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/toeplitz_word_streamer.sv
// Buffers extracted blocks and streams them MSB-first as OW-bit words over valid/ready,
// counting blocks that arrive while the buffer is full.
module toeplitz_word_streamer
    import toeplitz_pkg::*;
#(
    parameter int L     = DEFAULT_L,
    parameter int OW    = DEFAULT_OW,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [L-1:0]  q,
    input  logic          qstrobe,
    output logic [OW-1:0] dout,
    output logic          dvalid,
    input  logic          dready,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [CW-1:0] drop_cnt,
    output logic          busy
);

    localparam int WPB = words_per_block(L, OW);
    localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WPB - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    if (L % OW != 0) begin : g_bad_ow
        $error("toeplitz_word_streamer: L must be a multiple of OW");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("toeplitz_word_streamer: DEPTH must be a power of two >= 2");
    end

    logic [L-1:0]  head;
    logic [L-1:0]  head_shifted;
    logic          full;
    logic          empty;
    logic [IW-1:0] word_idx;
    logic          xfer;
    logic          last_xfer;
    logic          push;
    logic          drop;

    assign xfer      = dvalid && dready;
    assign last_xfer = xfer && (word_idx == LAST_IDX);
    // Popping the last word frees the head slot in time for a same-cycle arrival.
    assign push      = qstrobe && (!full || last_xfer);
    assign drop      = qstrobe && full && !last_xfer;

    block_fifo #(
        .W     (L),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (last_xfer),
        .data_in  (q),
        .data_out (head),
        .full     (full),
        .empty    (empty)
    );

    assign head_shifted = head << (int'(word_idx) * OW);
    assign dout         = empty ? '0 : head_shifted[L-1 -: OW];
    assign dvalid       = !empty;
    assign busy         = !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx <= '0;
        end else if (xfer) begin
            word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + IW'(1);
        end
    end

    // A drop coinciding with a clear restarts the count at one rather than losing the event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr)
                drop_cnt <= CW'(1);
            else if (drop_cnt != CNT_MAX)
                drop_cnt <= drop_cnt + CW'(1);
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_toeplitz_word_streamer.sv
// Self-checking bench for toeplitz_word_streamer: directed vectors for ordering, overflow,
// collision and reset cases, then randomized traffic against a word-queue reference model.
module tb_toeplitz_word_streamer;

    localparam int L     = 128;
    localparam int OW    = 8;
    localparam int DEPTH = 2;
    localparam int CW    = 16;
    localparam int WPB   = L / OW;

    logic          clk;
    logic          reset;
    logic [L-1:0]  q;
    logic          qstrobe;
    logic [OW-1:0] dout;
    logic          dvalid;
    logic          dready;
    logic          overflow;
    logic          ovf_clr;
    logic [CW-1:0] drop_cnt;
    logic          busy;

    int compared;
    int mismatched;

    toeplitz_word_streamer #(
        .L     (L),
        .OW    (OW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .q        (q),
        .qstrobe  (qstrobe),
        .dout     (dout),
        .dvalid   (dvalid),
        .dready   (dready),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            strobe;
        logic [L-1:0]  blk;
        bit            rdy;
        bit            clr;
        bit            exp_dvalid;
        bit            exp_busy;
        bit            exp_ovf;
        logic [CW-1:0] exp_drop;
        logic [OW-1:0] exp_dout;
    } vec_t;

    function automatic logic [OW-1:0] word_of(input logic [L-1:0] b, input int k);
        return b[L-1-k*OW -: OW];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read back at the next falling edge.
    task automatic applyStimulus(input bit strb, input logic [L-1:0] blk, input bit rdy, input bit clr);
        qstrobe = strb;
        q       = blk;
        dready  = rdy;
        ovf_clr = clr;
        @(posedge clk);
        @(negedge clk);
        qstrobe = 1'b0;
        ovf_clr = 1'b0;
    endtask

    logic [L-1:0]  blk1;
    logic [OW-1:0] exp1 [WPB];
    logic [L-1:0]  blk_a, blk_b, blk_c, blk_d, blk_e;
    vec_t          tbl [6];

    logic [OW-1:0] model_q [$];
    bit            model_ovf;
    logic [CW-1:0] model_drop;

    initial begin
        compared   = 0;
        mismatched = 0;
        reset   = 1'b0;
        q       = '0;
        qstrobe = 1'b0;
        dready  = 1'b0;
        ovf_clr = 1'b0;

        blk1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        exp1  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                  8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
        blk_a = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
        blk_b = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
        blk_c = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
        blk_d = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
        blk_e = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;

        // strobe blk rdy clr | dvalid busy ovf drop dout
        tbl[0] = '{1'b1, blk_a, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 8'hA0};
        tbl[1] = '{1'b1, blk_b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 8'hA0};
        tbl[2] = '{1'b1, blk_c, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 8'hA0};
        tbl[3] = '{1'b1, blk_c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 8'hA0};
        tbl[4] = '{1'b0, blk_c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 8'hA0};
        tbl[5] = '{1'b1, blk_c, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 8'hA0};

        repeat (3) @(negedge clk);
        checkOutput("reset_dvalid", dvalid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_dout", dout, 8'h00);
        checkOutput("reset_overflow", overflow, 1'b0);
        checkOutput("reset_drop_cnt", drop_cnt, 16'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single block at full rate: first word one cycle after the strobe.
        applyStimulus(1'b1, blk1, 1'b1, 1'b0);
        for (int k = 0; k < WPB; k++) begin
            checkOutput($sformatf("single_dvalid_%0d", k), dvalid, 1'b1);
            checkOutput($sformatf("single_word_%0d", k), dout, exp1[k]);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("single_dvalid_end", dvalid, 1'b0);
        checkOutput("single_busy_end", busy, 1'b0);

        // Full FIFO, new block arrives as the head's last word leaves.
        applyStimulus(1'b1, blk_a, 1'b0, 1'b0);
        applyStimulus(1'b1, blk_b, 1'b0, 1'b0);
        for (int k = 0; k < WPB; k++) begin
            checkOutput($sformatf("coll_a_word_%0d", k), dout, word_of(blk_a, k));
            applyStimulus(k == WPB - 1, blk_c, 1'b1, 1'b0);
        end
        for (int k = 0; k < 2 * WPB; k++) begin
            checkOutput($sformatf("coll_bc_dvalid_%0d", k), dvalid, 1'b1);
            checkOutput($sformatf("coll_bc_word_%0d", k), dout,
                        (k < WPB) ? word_of(blk_b, k) : word_of(blk_c, k - WPB));
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("coll_dvalid_end", dvalid, 1'b0);
        checkOutput("coll_drop_cnt", drop_cnt, 16'd0);
        checkOutput("coll_overflow", overflow, 1'b0);

        // Overflow / clear vectors with the consumer stalled.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].strobe, tbl[i].blk, tbl[i].rdy, tbl[i].clr);
            checkOutput($sformatf("tbl%0d_dvalid", i), dvalid, tbl[i].exp_dvalid);
            checkOutput($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            checkOutput($sformatf("tbl%0d_overflow", i), overflow, tbl[i].exp_ovf);
            checkOutput($sformatf("tbl%0d_drop_cnt", i), drop_cnt, tbl[i].exp_drop);
            checkOutput($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
        end
        for (int k = 0; k < 2 * WPB; k++) begin
            checkOutput($sformatf("ovf_drain_word_%0d", k), dout,
                        (k < WPB) ? word_of(blk_a, k) : word_of(blk_b, k - WPB));
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("ovf_drain_dvalid_end", dvalid, 1'b0);

        // Reset in the middle of a block throws away everything held.
        applyStimulus(1'b1, blk_d, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("mid_word5", dout, word_of(blk_d, 5));
        reset = 1'b0;
        #1;
        checkOutput("mid_reset_dvalid", dvalid, 1'b0);
        checkOutput("mid_reset_drop_cnt", drop_cnt, 16'd0);
        checkOutput("mid_reset_overflow", overflow, 1'b0);
        checkOutput("mid_reset_dout", dout, 8'h00);
        @(negedge clk);
        applyStimulus(1'b1, blk_c, 1'b1, 1'b0);
        reset = 1'b1;
        checkOutput("mid_strobe_ignored", dvalid, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, blk_e, 1'b1, 1'b0);
        for (int k = 0; k < WPB; k++) begin
            checkOutput($sformatf("post_reset_word_%0d", k), dout, word_of(blk_e, k));
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("post_reset_dvalid_end", dvalid, 1'b0);

        // Random traffic against a queue of pending words.
        model_q.delete();
        model_ovf  = 1'b0;
        model_drop = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit            strb, rdy, clr, xfer, last, accept;
            int            occ, head_left;
            logic [L-1:0]  blk, tmp;

            strb = ($urandom_range(0, 9) == 0);
            rdy  = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 79) == 0);
            blk  = {$urandom, $urandom, $urandom, $urandom};

            checkOutput("rnd_dvalid", dvalid, model_q.size() > 0);
            checkOutput("rnd_busy", busy, model_q.size() > 0);
            if (model_q.size() > 0) checkOutput("rnd_dout", dout, model_q[0]);
            checkOutput("rnd_overflow", overflow, model_ovf);
            checkOutput("rnd_drop_cnt", drop_cnt, model_drop);

            occ       = (model_q.size() + WPB - 1) / WPB;
            head_left = (model_q.size() == 0) ? 0 : ((model_q.size() - 1) % WPB) + 1;
            xfer      = (model_q.size() > 0) && rdy;
            last      = xfer && (head_left == 1);
            accept    = strb && (occ < DEPTH || last);
            if (xfer) void'(model_q.pop_front());
            if (accept) begin
                tmp = blk;
                for (int k = 0; k < WPB; k++) begin
                    model_q.push_back(tmp[L-1 -: OW]);
                    tmp = tmp << OW;
                end
            end
            if (strb && !accept) begin
                model_ovf  = 1'b1;
                model_drop = clr ? CW'(1) : ((model_drop == '1) ? model_drop : model_drop + CW'(1));
            end else if (clr) begin
                model_ovf  = 1'b0;
                model_drop = '0;
            end

            applyStimulus(strb, blk, rdy, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
